// File: rtl/fir_out_fifo.sv
// Output stage for the FIR: scales each result by an arithmetic right shift,
// saturates it to OUTW bits and queues it in a FIFO popped one sample per read.
module fir_out_fifo #(
    parameter int OW    = 31,
    parameter int OUTW  = 16,
    parameter int SHIFT = 11,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clr,
    input  logic                       i_valid,
    input  logic signed [OW-1:0]       i_result,
    input  logic                       i_rd,
    output logic signed [OUTW-1:0]     o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_underflow,
    output logic [15:0]                o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Shift first, then clamp: the shifted value fits in OUTW bits only when
    // every bit from the OUTW-1 position upwards is a copy of the sign bit.
    function automatic logic signed [OUTW-1:0] scale_sat(input logic signed [OW-1:0] v);
        logic signed [OW-1:0] s;
        s = v >>> SHIFT;
        if ((&s[OW-1:OUTW-1]) || !(|s[OW-1:OUTW-1]))
            return signed'(s[OUTW-1:0]);
        else if (s[OW-1])
            return signed'({1'b1, {(OUTW-1){1'b0}}});
        else
            return signed'({1'b0, {(OUTW-1){1'b1}}});
    endfunction

    logic signed [OUTW-1:0] data_p1_q;
    logic                   vld_p1_q, vld_p1_d;
    logic [OUTW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic signed [OUTW-1:0] rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic [15:0]            drop_q, drop_d;
    logic                   pop, push, drop;

    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign pop  = i_rd && (count_q != '0);
    assign push = vld_p1_q && ((count_q != DEPTH_C) || pop);
    assign drop = vld_p1_q && (count_q == DEPTH_C) && !pop;

    always_comb begin
        vld_p1_d   = vld_p1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        drop_d     = drop_q;
        if (i_clr) begin
            vld_p1_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            vld_p1_d = i_valid;
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = signed'(mem_q[rd_ptr_q]);
                rd_valid_d = 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (i_rd && (count_q == '0))
                unf_d = 1'b1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
            end
        end
    end

    // Stage 1 -> stage 2 control state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            drop_q     <= drop_d;
        end
    end

    // Datapath: stage-1 sample register and FIFO storage carry no reset
    always_ff @(posedge i_clk) begin
        data_p1_q <= scale_sat(i_result);
        if (push && !i_clr)
            mem_q[wr_ptr_q] <= data_p1_q;
    end

    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == DEPTH_C);
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: a queue of expected samples is filled as
// results are driven and drained as pops complete.
module tb_fir_out_fifo;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_clr = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [30:0] i_result = '0;
    logic               i_rd = 1'b0;
    logic signed [15:0] o_rd_data;
    logic               o_rd_valid;
    logic [4:0]         o_count;
    logic               o_empty, o_full, o_overflow, o_underflow;
    logic [15:0]        o_drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [15:0] q[$];
    logic [15:0] held;
    logic signed [30:0] r;

    fir_out_fifo #(.OW(31), .OUTW(16), .SHIFT(11), .DEPTH(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clr), .i_valid(i_valid),
        .i_result(i_result), .i_rd(i_rd), .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid), .o_count(o_count), .o_empty(o_empty),
        .o_full(o_full), .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] model(input logic signed [30:0] x);
        longint v;
        v = x;
        v = v >>> 11;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check a pop that completed at the last edge against the queue head.
    task automatic chk_pop(input string tag);
        logic [15:0] e;
        chk({tag, "_vld"}, {31'd0, o_rd_valid}, 32'd1);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=pop expected=no_pending_entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_data"}, {16'd0, o_rd_data}, {16'd0, e});
        end
    endtask

    task automatic pop_one(input string tag);
        i_rd = 1'b1;
        tick();
        i_rd = 1'b0;
        chk_pop(tag);
    endtask

    task automatic chk_flags_clear(input string tag);
        chk({tag, "_count"}, {27'd0, o_count}, 32'd0);
        chk({tag, "_empty"}, {31'd0, o_empty}, 32'd1);
        chk({tag, "_full"}, {31'd0, o_full}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, o_overflow}, 32'd0);
        chk({tag, "_unf"}, {31'd0, o_underflow}, 32'd0);
        chk({tag, "_drop"}, {16'd0, o_drop_cnt}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        i_reset = 1'b0;
        chk_flags_clear("rst");
        chk("rst_rdvld", {31'd0, o_rd_valid}, 32'd0);
        chk("rst_rddata", {16'd0, o_rd_data}, 32'd0);

        // Latency and scaling of 2048
        i_valid = 1'b1; i_result = 31'sd2048; q.push_back(16'h0001);
        tick();
        i_valid = 1'b0;
        chk("lat_empty_e0", {31'd0, o_empty}, 32'd1);
        tick();
        chk("lat_empty_e1", {31'd0, o_empty}, 32'd0);
        chk("lat_count_e1", {27'd0, o_count}, 32'd1);
        pop_one("lat_pop");
        tick();
        chk("lat_vld_pulse", {31'd0, o_rd_valid}, 32'd0);
        chk("lat_hold", {16'd0, o_rd_data}, 32'h0001);

        // Scaling boundaries and random values streamed back-to-back
        i_valid = 1'b1;
        i_result = -31'sd2048;      q.push_back(16'hFFFF); tick();
        i_result = 31'sd134217728;  q.push_back(16'h7FFF); tick();
        i_result = -31'sd134217728; q.push_back(16'h8000); tick();
        for (int i = 0; i < 6; i++) begin
            r = 31'($urandom);
            i_result = r;
            q.push_back(model(r));
            tick();
        end
        i_valid = 1'b0;
        tick();
        chk("scale_count", {27'd0, o_count}, 32'd9);
        for (int i = 0; i < 9; i++) pop_one("scale_pop");
        chk("scale_empty", {31'd0, o_empty}, 32'd1);

        // Underflow leaves data untouched; clear wipes the flag
        held = o_rd_data;
        i_rd = 1'b1; tick(); i_rd = 1'b0;
        chk("unf_flag", {31'd0, o_underflow}, 32'd1);
        chk("unf_novld", {31'd0, o_rd_valid}, 32'd0);
        chk("unf_hold", {16'd0, o_rd_data}, {16'd0, held});
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        chk("unf_clr", {31'd0, o_underflow}, 32'd0);
        chk("clr_keep", {16'd0, o_rd_data}, {16'd0, held});

        // Result coincident with clear is discarded
        i_clr = 1'b1; i_valid = 1'b1; i_result = 31'sd4096;
        tick();
        i_clr = 1'b0; i_valid = 1'b0;
        tick();
        chk("clr_discard", {27'd0, o_count}, 32'd0);

        // Overflow: 20 results into 16 entries
        i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_result = 31'(k + 1) * 31'sd4096;
            if (q.size() < 16) q.push_back(model(i_result));
            tick();
        end
        i_valid = 1'b0;
        tick();
        chk("ovf_full", {31'd0, o_full}, 32'd1);
        chk("ovf_count", {27'd0, o_count}, 32'd16);
        chk("ovf_drop", {16'd0, o_drop_cnt}, 32'd4);
        chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
        for (int i = 0; i < 16; i++) pop_one("ovf_pop");
        chk("ovf_empty", {31'd0, o_empty}, 32'd1);

        // Simultaneous read and write while full, wrapping the pointers
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            r = 31'($urandom);
            i_result = r;
            q.push_back(model(r));
            tick();
        end
        r = 31'($urandom); i_result = r; q.push_back(model(r));
        tick();
        chk("rw_count0", {27'd0, o_count}, 32'd16);
        for (int i = 0; i < 40; i++) begin
            i_rd = 1'b1;
            i_valid = (i < 39);
            if (i < 39) begin
                r = 31'($urandom);
                i_result = r;
                q.push_back(model(r));
            end
            tick();
            chk_pop("rw_pop");
            chk("rw_count", {27'd0, o_count}, 32'd16);
        end
        i_rd = 1'b0; i_valid = 1'b0;
        tick();
        chk("rw_drop", {16'd0, o_drop_cnt}, 32'd0);
        chk("rw_full", {31'd0, o_full}, 32'd1);
        for (int i = 0; i < 16; i++) pop_one("rw_drain");
        chk("rw_empty", {31'd0, o_empty}, 32'd1);

        // Reset mid-stream: 5 buffered, one in stage 1, one sampled with reset
        i_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_result = 31'sd8192 * 31'(k + 1);
            tick();
        end
        chk("mid_count", {27'd0, o_count}, 32'd5);
        i_reset = 1'b1; i_result = 31'sd65536;
        tick();
        i_reset = 1'b0; i_valid = 1'b0;
        tick();
        chk_flags_clear("mid_rst");
        chk("mid_rddata", {16'd0, o_rd_data}, 32'd0);
        i_rd = 1'b1; tick(); i_rd = 1'b0;
        chk("mid_nostale", {31'd0, o_rd_valid}, 32'd0);
        chk("mid_unf", {31'd0, o_underflow}, 32'd1);
        i_valid = 1'b1; i_result = -31'sd6144; q.push_back(16'hFFFD);
        tick();
        i_valid = 1'b0;
        tick();
        pop_one("mid_fresh");
        chk("mid_empty", {31'd0, o_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
